// File: rtl/serial_pad_scanner.sv
// serial_pad_scanner
// Polls NUM_PADS NES/SNES-style serial game pads in parallel. All pads share one
// latch/sclk pair; each pad has its own sdata line. A scan is started by the
// free-running poll counter or by poll_now, but only while idle and enabled.
// Ports:
//   clk       system clock
//   reset     asynchronous, active-low reset
//   enable    permits new scans (auto or manual)
//   poll_now  single-cycle request for an immediate scan
//   sdata     serial data from each pad, low = pressed
//   latch     parallel-load strobe to all pads
//   sclk      shift clock to all pads, idle high
//   state     IDLE=00, LATCH=01, CAPTURE=11, DONE=10
//   buttons   pad p bit i at index p*NUM_BITS+i, 1 = pressed, held between scans
//   pressed   one-cycle pulse per button on a 0->1 change of buttons
//   valid     one-cycle pulse in the cycle buttons takes its new value
module serial_pad_scanner #(
  parameter int NUM_PADS     = 2,
  parameter int NUM_BITS     = 8,
  parameter int LATCH_CYCLES = 144,
  parameter int HALF_CYCLES  = 72,
  parameter int POLL_CYCLES  = 200000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         poll_now,
  input  logic [NUM_PADS-1:0]          sdata,
  output logic                         latch,
  output logic                         sclk,
  output logic [1:0]                   state,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic                         valid
);

  localparam int W           = NUM_PADS * NUM_BITS;
  localparam int SLOT_CYCLES = 2 * HALF_CYCLES;
  localparam int CNT_MAX     = (LATCH_CYCLES > SLOT_CYCLES) ? LATCH_CYCLES : SLOT_CYCLES;
  localparam int CW          = $clog2(CNT_MAX + 1);
  localparam int BW          = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int PW          = $clog2(POLL_CYCLES + 1);

  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] HALF       = CW'(HALF_CYCLES);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BITS - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_LATCH   = 2'b01,
    ST_CAPTURE = 2'b11,
    ST_DONE    = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [PW-1:0]       poll_cnt_q, poll_cnt_d;
  logic [NUM_PADS-1:0] sync1_q, sync2_q;
  logic [W-1:0]        sampled_q, sampled_d;
  logic [W-1:0]        buttons_q, buttons_d;
  logic [W-1:0]        pressed_q, pressed_d;
  logic                valid_q, valid_d;
  logic                latch_q, latch_d;
  logic                sclk_q, sclk_d;
  logic                tick_s;
  logic                start_s;

  assign tick_s  = (poll_cnt_q == POLL_LAST);
  // Requests arriving outside IDLE are simply lost; nothing is queued.
  assign start_s = (state_q == ST_IDLE) && enable && (tick_s || poll_now);

  // Poll counter runs in every state and wraps to produce the auto-poll tick.
  always_comb begin
    poll_cnt_d = poll_cnt_q;
    if (tick_s) begin
      poll_cnt_d = '0;
    end else begin
      poll_cnt_d = poll_cnt_q + 1'b1;
    end
  end

  // Input synchroniser and poll counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      poll_cnt_q <= '0;
    end else begin
      sync1_q    <= sdata;
      sync2_q    <= sync1_q;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  // Scan sequencer: next state, slot counters, bit capture and result publishing.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    sampled_d = sampled_q;
    buttons_d = buttons_q;
    pressed_d = '0;
    valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_LATCH;
          cyc_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (cyc_q == LATCH_LAST) begin
          state_d = ST_CAPTURE;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        // Sample on the first cycle of each slot (sclk falling); the pad shifted
        // on the previous rise, HALF_CYCLES earlier, which covers the synchroniser.
        if (cyc_q == '0) begin
          for (int p = 0; p < NUM_PADS; p++) begin
            for (int i = 0; i < NUM_BITS; i++) begin
              if (bit_q == BW'(i)) begin
                sampled_d[p*NUM_BITS+i] = sync2_q[p];
              end else begin
                sampled_d[p*NUM_BITS+i] = sampled_q[p*NUM_BITS+i];
              end
            end
          end
        end else begin
          sampled_d = sampled_q;
        end
        if (cyc_q == SLOT_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            // Results are registered on entry to DONE so they appear with valid.
            state_d   = ST_DONE;
            buttons_d = ~sampled_q;
            pressed_d = ~sampled_q & ~buttons_q;
            valid_d   = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Pad strobes are decoded from the next state so they leave a flop cleanly.
    latch_d = (state_d == ST_LATCH);
    sclk_d  = ~((state_d == ST_CAPTURE) && (cyc_d < HALF));
  end

  // Sequencer, result and strobe registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      bit_q     <= '0;
      sampled_q <= '1;
      buttons_q <= '0;
      pressed_q <= '0;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      sclk_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      sampled_q <= sampled_d;
      buttons_q <= buttons_d;
      pressed_q <= pressed_d;
      valid_q   <= valid_d;
      latch_q   <= latch_d;
      sclk_q    <= sclk_d;
    end
  end

  assign latch   = latch_q;
  assign sclk    = sclk_q;
  assign state   = state_q;
  assign buttons = buttons_q;
  assign pressed = pressed_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_serial_pad_scanner.sv
// Bench for serial_pad_scanner: an NES configuration (2 pads x 8 bits) and an
// SNES configuration (2 pads x 16 bits) driven by behavioural pads that load on
// latch rise, shift on sclk rise and drive 1 after their last bit.
module tb_serial_pad_scanner;
  localparam int LC = 12;
  localparam int HC = 6;
  localparam int PC = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        poll8 = 1'b0;
  logic        poll16 = 1'b0;
  logic [1:0]  sdata8, sdata16;
  logic        latch8, sclk8, valid8, latch16, sclk16, valid16;
  logic [1:0]  state8, state16;
  logic [15:0] btn8, pr8;
  logic [31:0] btn16, pr16;

  int          n_vec = 0;
  int          n_err = 0;
  int          edge_cnt = 0;
  int          rel = 0;
  logic [15:0] prev8 = 16'h0;
  logic [31:0] prev16 = 32'h0;

  logic [7:0]  held8 [2];
  logic        disc8 [2];
  logic [23:0] sh8 [2];
  logic [15:0] held16 [2];
  logic [23:0] sh16 [2];

  serial_pad_scanner #(.NUM_PADS(2), .NUM_BITS(8), .LATCH_CYCLES(LC),
                       .HALF_CYCLES(HC), .POLL_CYCLES(PC)) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable), .poll_now(poll8), .sdata(sdata8),
    .latch(latch8), .sclk(sclk8), .state(state8), .buttons(btn8),
    .pressed(pr8), .valid(valid8));

  serial_pad_scanner #(.NUM_PADS(2), .NUM_BITS(16), .LATCH_CYCLES(LC),
                       .HALF_CYCLES(HC), .POLL_CYCLES(PC)) u_dut16 (
    .clk(clk), .reset(reset), .enable(enable), .poll_now(poll16), .sdata(sdata16),
    .latch(latch16), .sclk(sclk16), .state(state16), .buttons(btn16),
    .pressed(pr16), .valid(valid16));

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Behavioural pads: a rising edge with latch high is a load, otherwise a shift.
  always @(posedge latch8 or posedge sclk8) begin
    for (int p = 0; p < 2; p++) begin
      if (latch8) sh8[p] <= {16'hFFFF, ~held8[p]};
      else        sh8[p] <= {1'b1, sh8[p][23:1]};
    end
  end
  always @(posedge latch16 or posedge sclk16) begin
    for (int p = 0; p < 2; p++) begin
      if (latch16) sh16[p] <= {8'hFF, ~held16[p]};
      else         sh16[p] <= {1'b1, sh16[p][23:1]};
    end
  end
  always_comb begin
    sdata8  = 2'b11;
    sdata16 = 2'b11;
    for (int p = 0; p < 2; p++) begin
      sdata8[p]  = disc8[p] ? 1'b1 : sh8[p][0];
      sdata16[p] = sh16[p][0];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle8();
    int b = 0;
    while (state8 != 2'b00 && b < 400) begin
      @(negedge clk);
      b++;
    end
    check_val("idle8", {30'h0, state8}, 32'h0);
  endtask

  // Called at the negedge of cycle T+1 (first LATCH cycle); follows the scan to valid.
  task automatic observe8(input int drop_k, input logic [15:0] exp_btn);
    int k = 1;
    int lat = 0;
    int falls = 0;
    int kv = 0;
    int spur = 0;
    logic sprev = 1'b1;
    logic [15:0] gb = 16'h0;
    logic [15:0] gp = 16'h0;
    check_val("st_latch", {30'h0, state8}, 32'h1);
    while (kv == 0 && k < 400) begin
      if (k == drop_k) enable = 1'b0;
      if (k == LC + 1) check_val("st_capture", {30'h0, state8}, 32'h3);
      if (latch8) lat++;
      if (sprev && !sclk8) falls++;
      sprev = sclk8;
      if (valid8) begin
        kv = k;
        gb = btn8;
        gp = pr8;
        check_val("st_done", {30'h0, state8}, 32'h2);
      end else begin
        if (pr8 != 16'h0) spur++;
        @(negedge clk);
        k++;
      end
    end
    check_val("valid_k", kv, LC + 2*HC*8 + 1);
    check_val("latch_len", lat, LC);
    check_val("sclk_falls", falls, 8);
    check_val("pressed_early", spur, 0);
    check_val("buttons", {16'h0, gb}, {16'h0, exp_btn});
    check_val("pressed", {16'h0, gp}, {16'h0, exp_btn & ~prev8});
    prev8 = exp_btn;
    @(negedge clk);
    check_val("after_done", {13'h0, valid8, state8, pr8}, 32'h0);
    check_val("buttons_hold", {16'h0, btn8}, {16'h0, exp_btn});
    enable = 1'b1;
  endtask

  task automatic set_pads8(input logic [7:0] h0, input logic [7:0] h1, input logic d0, input logic d1);
    held8[0] = h0;
    held8[1] = h1;
    disc8[0] = d0;
    disc8[1] = d1;
  endtask

  task automatic poll_scan8(input logic [7:0] h0, input logic [7:0] h1,
                            input logic d0, input logic d1, input int drop_k);
    wait_idle8();
    set_pads8(h0, h1, d0, d1);
    poll8 = 1'b1;
    @(negedge clk);
    poll8 = 1'b0;
    observe8(drop_k, {(d1 ? 8'h00 : h1), (d0 ? 8'h00 : h0)});
  endtask

  task automatic tick_scan8(input logic [7:0] h0, input logic [7:0] h1, input logic d0, input logic d1);
    int b = 0;
    wait_idle8();
    set_pads8(h0, h1, d0, d1);
    while (!latch8 && b < 1200) begin
      @(negedge clk);
      b++;
    end
    check_val("tick_phase", (edge_cnt - rel) % PC, 0);
    observe8(0, {(d1 ? 8'h00 : h1), (d0 ? 8'h00 : h0)});
  endtask

  task automatic snes_scan(input logic [15:0] h1);
    int b = 0;
    int k = 1;
    int falls = 0;
    int kv = 0;
    logic sprev = 1'b1;
    logic [31:0] expb;
    while (state16 != 2'b00 && b < 400) begin
      @(negedge clk);
      b++;
    end
    held16[0] = 16'h0800;
    held16[1] = h1;
    expb = {h1, 16'h0800};
    poll16 = 1'b1;
    @(negedge clk);
    poll16 = 1'b0;
    while (kv == 0 && k < 400) begin
      if (sprev && !sclk16) falls++;
      sprev = sclk16;
      if (valid16) begin
        kv = k;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    check_val("snes_valid_k", kv, LC + 2*HC*16 + 1);
    check_val("snes_falls", falls, 16);
    check_val("snes_buttons", btn16, expb);
    check_val("snes_pressed", pr16, expb & ~prev16);
    prev16 = expb;
  endtask

  initial begin
    int bad;
    set_pads8(8'h00, 8'h00, 1'b0, 1'b0);
    held16[0] = 16'h0;
    held16[1] = 16'h0;
    repeat (3) @(negedge clk);
    check_val("rst_strobes", {27'h0, latch8, sclk8, state8, valid8}, {27'h0, 5'b01000});
    check_val("rst_words", {btn8, pr8}, 32'h0);
    reset = 1'b1;
    rel = edge_cnt;
    enable = 1'b1;

    snes_scan(16'h0000);
    snes_scan(16'h9001);

    poll_scan8(8'h01, 8'h00, 1'b0, 1'b0, 0);
    tick_scan8(8'h01, 8'h08, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      poll_scan8(8'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0), 0);
    end
    tick_scan8(8'($urandom), 8'($urandom), 1'b0, 1'b1);

    // Disabled: neither poll_now nor the auto tick may start a scan.
    wait_idle8();
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 1100; i++) begin
      poll8 = (i % 97 == 0);
      @(negedge clk);
      if (state8 != 2'b00 || latch8) bad++;
    end
    poll8 = 1'b0;
    check_val("disabled_quiet", bad, 0);
    enable = 1'b1;

    // enable dropped during CAPTURE: the scan still completes.
    poll_scan8(8'($urandom), 8'($urandom), 1'b0, 1'b0, 30);

    // Reset during CAPTURE slot 3.
    poll_scan8(8'h5A, 8'hC3, 1'b0, 1'b0, 0);
    wait_idle8();
    set_pads8(8'h11, 8'h22, 1'b0, 1'b0);
    poll8 = 1'b1;
    @(negedge clk);
    poll8 = 1'b0;
    repeat (LC + 3*2*HC + 3) @(negedge clk);
    check_val("rst_pre_state", {30'h0, state8}, 32'h3);
    reset = 1'b0;
    #1;
    check_val("rst_mid_strobes", {27'h0, latch8, sclk8, state8, valid8}, {27'h0, 5'b01000});
    check_val("rst_mid_words", {btn8, pr8}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rel = edge_cnt;
    prev8 = 16'h0;
    poll_scan8(8'h80, 8'h41, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_pad_scanner.md
Name: serial_pad_scanner

Overview:
- Parametrised successor to the single NES pad reader.
- Polls NUM_PADS daisy-less serial game pads (NES 8-bit or SNES 16-bit shift-register protocol) in parallel over a shared latch/sclk pair with one sdata line per pad.
- Publishes debounce-free active-high button words, a per-scan valid strobe, and per-button press-edge pulses.
- Sits between the pad connectors and the user logic (LEDs, game cores).

Parameters:
NUM_PADS, 2, number of pads scanned in parallel (1..4)
NUM_BITS, 8, bits per pad (8 = NES, 16 = SNES)
LATCH_CYCLES, 144, clk cycles latch is held high (12 us at 12 MHz)
HALF_CYCLES, 72, clk cycles per sclk half period (>= 4)
POLL_CYCLES, 200000, auto-poll period in clk cycles (60 Hz at 12 MHz); must exceed scan length

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  permits new scans (auto or manual)
poll_now  in  1  request an immediate scan (single-cycle pulse)
sdata  in  NUM_PADS  serial data from each pad; low = pressed
latch  out  1  parallel-load strobe to all pads
sclk  out  1  shift clock to all pads; idle high
state  out  2  FSM state: IDLE=00, LATCH=01, CAPTURE=11, DONE=10
buttons  out  NUM_PADS*NUM_BITS  pad p bit i at index p*NUM_BITS+i; 1 = pressed
pressed  out  NUM_PADS*NUM_BITS  one-cycle pulse on 0->1 transition of buttons
valid  out  1  one-cycle pulse when buttons updated

Behaviour:
Clock and reset:
- One clock (clk); reset is asynchronous and active-low.
- On reset: state=IDLE, latch=0, sclk=1, buttons=0, pressed=0, valid=0, poll counter=0, synchroniser flops=1.
- Reset mid-scan aborts the scan immediately; no valid is issued.

Input synchronisation:
- Each sdata bit passes a 2-flop synchroniser; all sampling uses the synchronised value.

Poll counter:
- Counts every cycle in all states; wraps at POLL_CYCLES-1, producing a one-cycle tick.
- Start condition: state==IDLE and enable and (tick or poll_now).
- tick or poll_now outside IDLE is dropped, not queued.

FSM, with start seen at cycle T:
- IDLE: latch=0, sclk=1. Go to LATCH on the start condition.
- LATCH: cycles T+1 .. T+LATCH_CYCLES; latch=1, sclk=1. Then CAPTURE.
- CAPTURE: NUM_BITS bit slots of 2*HALF_CYCLES cycles each.
  - In slot i, sclk=0 for the first HALF_CYCLES cycles, then 1.
  - Bit i of every pad is sampled into a shift register on the first cycle of slot i (sclk falling).
  - Pads shift on each sclk rise, so bit i+1 is stable by slot i+1.
  - After the last slot, go to DONE.
- DONE: one cycle.
  - buttons <= ~sampled.
  - pressed <= ~sampled & ~buttons_old.
  - valid=1.
  - Then IDLE.
- valid occurs at T+LATCH_CYCLES+2*HALF_CYCLES*NUM_BITS+1.

Output behaviour:
- pressed and valid are high only in the DONE cycle; 0 otherwise.
- buttons holds between scans.
- enable deasserted mid-scan: the current scan completes normally; no further scans start.
- Disconnected pad (sdata pulled high): its button word reads all 0.

Test Plan:
1. Bench setup for all scenarios: LATCH_CYCLES=12, HALF_CYCLES=6, POLL_CYCLES=1000, NUM_BITS=8, NUM_PADS=2. Behavioural pads load on latch rise, shift on sclk rise, and drive 1 after the last bit.
2. poll_now at T with pad0 A held (bit0 low) -> latch high T+1..T+12; 8 sclk low pulses; valid at T+109; buttons=16'h0001; pressed=16'h0001.
3. Same pad0 held, pad1 START held (index 11), next auto tick -> buttons=16'h0801; pressed=16'h0800 (A not re-pulsed).
4. NUM_BITS=16 (SNES) with pad0 R held (bit11) -> 16 sclk pulses; valid at T+205; buttons[11]=1, all other bits 0.
5. enable=0 with poll_now pulses and ticks -> state stays 00, latch stays 0; enable dropped during CAPTURE -> that scan still ends with valid.
6. reset asserted in CAPTURE slot 3 -> same cycle: latch=0, sclk=1, state=00, buttons=0; after release, the next poll produces a full scan.
